// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder/loader and the decode stage.
// Field positions here are the single source of truth for the 16-bit word layout.
package isa_pkg;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_BRANCH = 4'b0001;

    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned RD_LSB     = 9;
    localparam int unsigned RS_LSB     = 6;
    localparam int unsigned RT_LSB     = 3;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned OFFSET_LSB = 0;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StDone
    } state_e;

    // Branch func and I-type rt overlap offset/imm, so they are not placed separately.
    function automatic logic [15:0] encode_instr(
        input logic [3:0] opcode,
        input logic [2:0] rd,
        input logic [2:0] rs,
        input logic [2:0] rt,
        input logic [2:0] func,
        input logic [5:0] imm,
        input logic [8:0] offset
    );
        logic [15:0] w;
        w = '0;
        w[OPCODE_LSB +: 4] = opcode;
        if (opcode == OP_RTYPE) begin
            w[RD_LSB +: 3]   = rd;
            w[RS_LSB +: 3]   = rs;
            w[RT_LSB +: 3]   = rt;
            w[FUNC_LSB +: 3] = func;
        end else if (opcode == OP_BRANCH) begin
            w[OFFSET_LSB +: 9] = offset;
        end else begin
            w[RD_LSB +: 3]  = rd;
            w[RS_LSB +: 3]  = rs;
            w[IMM_LSB +: 6] = imm;
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-beat input stream and instruction-memory write port of the encoder/loader.
// slave is the loader side; master is the producer / memory side.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_opcode;
    logic [2:0]        in_rd;
    logic [2:0]        in_rs;
    logic [2:0]        in_rt;
    logic [2:0]        in_func;
    logic [5:0]        in_imm;
    logic [8:0]        in_offset;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_last, in_opcode, in_rd, in_rs, in_rt, in_func, in_imm, in_offset,
        output mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_last, in_opcode, in_rd, in_rs, in_rt, in_func, in_imm, in_offset,
        input  mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/instr_fifo.sv
// DEPTH x WIDTH synchronous FIFO with registered occupancy; full/empty come from the count.
// Push when full and pop when empty are ignored.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             one_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthC = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == DepthC);
    assign empty_o = (count_q == '0);
    assign one_o   = (count_q == (PtrW + 1)'(1));
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs instruction field beats into 16-bit words, buffers them and writes them
// sequentially into instruction memory from a programmable base address.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    instr_encoder_loader_if.slave     bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_conflict_o,
    output logic [ADDR_W:0]           word_count_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              err_q, err_d;

    logic        fifo_full, fifo_empty, fifo_one;
    logic [15:0] fifo_head, enc_word;
    logic        draining, accept, pop;

    assign draining      = (state_q == StLoad) || (state_q == StFlush);
    assign bus.in_ready  = (state_q == StLoad) & ~fifo_full;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.mem_we    = draining & ~fifo_empty;
    assign pop           = bus.mem_we & bus.mem_ready;
    assign bus.mem_addr  = wr_addr_q;
    assign bus.mem_wdata = bus.mem_we ? fifo_head : '0;

    assign enc_word = encode_instr(bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt,
                                   bus.in_func, bus.in_imm, bus.in_offset);

    assign busy_o         = draining;
    assign done_o         = (state_q == StDone);
    assign err_conflict_o = err_q;
    assign word_count_o   = word_count_q;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .data_i  (enc_word),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .one_o   (fifo_one),
        .head_o  (fifo_head)
    );

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        word_count_d = word_count_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d      = StLoad;
                    wr_addr_d    = base_addr_i;
                    word_count_d = '0;
                    err_d        = 1'b0;
                end
            end
            StLoad: begin
                if (accept && bus.in_last) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // Leave as the last word completes so DONE follows the final pop directly.
                if (fifo_empty || (pop && fifo_one)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (pop) begin
            wr_addr_d    = wr_addr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
        end

        if (accept && (bus.in_opcode == OP_BRANCH) && (bus.in_func != bus.in_offset[2:0])) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_addr_q    <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
        end
    end

endmodule
